// File: rtl/fifo_unloader.sv
// fifo_unloader
// Pulls alternating header/data words out of a standard (non-FWFT) FIFO,
// decodes the channel index carried by each header and rebuilds a complete
// NUM_CH x 16-bit frame. The frame is presented on a parallel bank that only
// changes on commit, with a one-cycle frame_valid strobe and sticky
// framing-error flags.
//
// Optional feature: define FIFO_UNLOADER_STATS_EN to build a 16-bit
// completed-frame counter on frame_cnt. Without it, frame_cnt is tied to 0.
//
// Ports
//   ti_clk       in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  FIFO read strobe (combinational)
//   hold         in   consumer backpressure, suppresses reads
//   err_clr      in   synchronous clear of hdr_err / seq_err
//   ch_data      out  frame bank, channel i at [16*i+15:16*i]
//   frame_valid  out  one-cycle pulse when ch_data updates
//   hdr_err      out  sticky, malformed header seen
//   seq_err      out  sticky, out-of-order channel seen
//   frame_cnt    out  completed-frame count (stats build only)
module fifo_unloader #(
  parameter int NUM_CH   = 8,
  parameter int TRAIL_CH = 8
) (
  input  logic                  ti_clk,
  input  logic                  rst_n,
  input  logic [15:0]           fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  hold,
  input  logic                  err_clr,
  output logic [16*NUM_CH-1:0]  ch_data,
  output logic                  frame_valid,
  output logic                  hdr_err,
  output logic                  seq_err,
  output logic [15:0]           frame_cnt
);

  // Header channel field is 4 bits wide; constants are sized to match it.
  localparam logic [3:0] TRAIL_IDX = 4'(TRAIL_CH);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_CH - 1);
  localparam logic [4:0] NUM_CH_W  = 5'(NUM_CH);

  typedef enum logic {EXP_HDR = 1'b0, EXP_DAT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 word_vld_q, word_vld_d;
  logic [3:0]           exp_ch_q, exp_ch_d;
  logic [3:0]           cur_ch_q, cur_ch_d;
  logic [15:0]          shadow_q [NUM_CH];
  logic [15:0]          shadow_d [NUM_CH];
  logic [16*NUM_CH-1:0] ch_data_q, ch_data_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 hdr_err_q, hdr_err_d;
  logic                 seq_err_q, seq_err_d;

  logic [3:0]           hdr_ch;
  logic                 hdr_ok;
  logic                 cur_is_data;

  // Reads are gated by rst_n so nothing is pulled from the FIFO during reset.
  assign fifo_rd_en = rst_n & ~fifo_empty & ~hold;

  assign hdr_ch      = fifo_dout[3:0];
  assign hdr_ok      = (fifo_dout[15:4] == 12'h000) && (hdr_ch <= TRAIL_IDX);
  assign cur_is_data = ({1'b0, cur_ch_q} < NUM_CH_W);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EXP_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  // A malformed header keeps us in EXP_HDR so the next word is retried as a
  // header; any word taken in EXP_DAT is data, whatever its contents.
  always_comb begin
    state_d = state_q;
    if (word_vld_q) begin
      case (state_q)
        EXP_HDR: if (hdr_ok) state_d = EXP_DAT;
        EXP_DAT: state_d = EXP_HDR;
        default: state_d = EXP_HDR;
      endcase
    end
  end

  // ------------------------------------------------------ outputs / datapath
  always_comb begin
    word_vld_d    = fifo_rd_en;
    exp_ch_d      = exp_ch_q;
    cur_ch_d      = cur_ch_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    // A fresh error on the same edge as err_clr overrides the clear below.
    hdr_err_d     = hdr_err_q & ~err_clr;
    seq_err_d     = seq_err_q & ~err_clr;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
    end

    if (word_vld_q) begin
      if (state_q == EXP_HDR) begin
        if (!hdr_ok) begin
          hdr_err_d = 1'b1;
        end else begin
          cur_ch_d = hdr_ch;
          if ((hdr_ch != exp_ch_q) && (hdr_ch != TRAIL_IDX)) begin
            seq_err_d = 1'b1;
          end
        end
      end else if (cur_is_data) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cur_ch_q == 4'(i)) shadow_d[i] = fifo_dout;
        end
        exp_ch_d = cur_ch_q + 4'd1;
        // Last channel commits the whole shadow, including the word arriving
        // on this edge, so the bank never shows a half-updated frame.
        if (cur_ch_q == LAST_IDX) begin
          for (int i = 0; i < NUM_CH; i++) begin
            ch_data_d[16*i +: 16] = shadow_d[i];
          end
          frame_valid_d = 1'b1;
          exp_ch_d      = 4'd0;
        end
      end else begin
        // Trailer (or any non-data channel that passed the header check):
        // payload dropped, next frame expected from channel 0.
        exp_ch_d = 4'd0;
      end
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_vld_q    <= 1'b0;
      exp_ch_q      <= 4'd0;
      cur_ch_q      <= 4'd0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      hdr_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= 16'h0000;
      end
    end else begin
      word_vld_q    <= word_vld_d;
      exp_ch_q      <= exp_ch_d;
      cur_ch_q      <= cur_ch_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      hdr_err_q     <= hdr_err_d;
      seq_err_q     <= seq_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign hdr_err     = hdr_err_q;
  assign seq_err     = seq_err_q;

  // ------------------------------------------------------------ frame counter
`ifdef FIFO_UNLOADER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge the bank commits; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_valid_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'h0000;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_unloader.sv
// Self-checking bench for fifo_unloader: a FIFO model feeds the DUT, and a
// word-stream reference model predicts committed frames and error flags.
module tb_fifo_unloader;

  logic         ti_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  fifo_dout = 16'h0000;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         hold = 1'b0;
  logic         err_clr = 1'b0;
  logic [127:0] ch_data;
  logic         frame_valid;
  logic         hdr_err;
  logic         seq_err;
  logic [15:0]  frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  fifo_unloader #(.NUM_CH(8), .TRAIL_CH(8)) dut (
    .ti_clk(ti_clk), .rst_n(rst_n), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .hold(hold),
    .err_clr(err_clr), .ch_data(ch_data), .frame_valid(frame_valid),
    .hdr_err(hdr_err), .seq_err(seq_err), .frame_cnt(frame_cnt)
  );

  always #5 ti_clk = ~ti_clk;
  always @(posedge ti_clk) cyc <= cyc + 1;

  // ---------------- FIFO model (standard read: data the cycle after rd_en)
  logic [15:0] mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  force_empty = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

  always @(posedge ti_clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- capture of committed frames
  logic [127:0] got_frames [$];
  int           got_cyc [$];

  always @(negedge ti_clk) begin
    if (rst_n && frame_valid) begin
      got_frames.push_back(ch_data);
      got_cyc.push_back(cyc);
    end
  end

  // ---------------- reference model over the word stream
  bit           m_want_hdr = 1'b1;
  int           m_exp = 0;
  int           m_cur = 0;
  logic [15:0]  m_sh [8];
  logic [127:0] m_bank = '0;
  bit           m_he = 1'b0;
  bit           m_se = 1'b0;
  int           m_cnt = 0;
  logic [127:0] exp_frames [$];

  task automatic model_reset();
    m_want_hdr = 1'b1; m_exp = 0; m_cur = 0; m_bank = '0;
    m_he = 1'b0; m_se = 1'b0; m_cnt = 0;
    for (int i = 0; i < 8; i++) m_sh[i] = 16'h0000;
  endtask

  task automatic model_word(input logic [15:0] w);
    if (m_want_hdr) begin
      if (w[15:4] != 12'h000 || w[3:0] > 4'd8) begin
        m_he = 1'b1;
      end else begin
        m_cur = int'(w[3:0]);
        m_want_hdr = 1'b0;
        if (m_cur != m_exp && m_cur != 8) m_se = 1'b1;
      end
    end else begin
      m_want_hdr = 1'b1;
      if (m_cur < 8) begin
        m_sh[m_cur] = w;
        m_exp = m_cur + 1;
        if (m_cur == 7) begin
          for (int i = 0; i < 8; i++) m_bank[16*i +: 16] = m_sh[i];
          exp_frames.push_back(m_bank);
          m_cnt = (m_cnt + 1) % 65536;
          m_exp = 0;
        end
      end else begin
        m_exp = 0;
      end
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef FIFO_UNLOADER_STATS_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr = wr_ptr + 1;
    model_word(w);
  endtask

  task automatic push_pair(input int ch, input logic [15:0] d);
    push_word(16'(ch));
    push_word(d);
  endtask

  // ---------------- checking helpers
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (rd_ptr != wr_ptr && n < 5000) begin
      @(negedge ti_clk);
      if (rnd) begin
        hold        = ($urandom % 4) == 0;
        force_empty = ($urandom % 5) == 0;
      end
      n++;
    end
    hold = 1'b0;
    force_empty = 1'b0;
    repeat (3) @(negedge ti_clk);
    check("drain_timeout", 128'(n >= 5000), 128'(0));
  endtask

  task automatic check_all(input string tag);
    int n;
    $display("step %s: frames got=%0d exp=%0d hdr_err=%0b seq_err=%0b frame_cnt=%0d",
             tag, got_frames.size(), exp_frames.size(), hdr_err, seq_err, frame_cnt);
    check({tag, "_nframes"}, 128'(got_frames.size()), 128'(exp_frames.size()));
    n = (got_frames.size() < exp_frames.size()) ? got_frames.size() : exp_frames.size();
    for (int i = 0; i < n; i++) check({tag, "_frame"}, got_frames[i], exp_frames[i]);
    check({tag, "_bank"}, ch_data, m_bank);
    check({tag, "_hdr_err"}, 128'(hdr_err), 128'(m_he));
    check({tag, "_seq_err"}, 128'(seq_err), 128'(m_se));
    check({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_cnt()));
    got_frames.delete();
    got_cyc.delete();
    exp_frames.delete();
  endtask

  task automatic pulse_err_clr();
    @(negedge ti_clk) err_clr = 1'b1;
    @(negedge ti_clk) err_clr = 1'b0;
    m_he = 1'b0;
    m_se = 1'b0;
  endtask

  task automatic push_std_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) push_pair(i, base + 16'(i));
  endtask

  // ---------------- directed + randomized sequence
  initial begin
    int start;
    int ty, badpos, dropch, a, b, t;
    int ord [8];
    logic [15:0] bad;

    model_reset();
    repeat (3) @(negedge ti_clk);
    check("reset_rd_en", 128'(fifo_rd_en), 128'(0));
    check("reset_ch_data", ch_data, 128'(0));
    check("reset_frame_valid", 128'(frame_valid), 128'(0));
    check("reset_hdr_err", 128'(hdr_err), 128'(0));
    check("reset_seq_err", 128'(seq_err), 128'(0));
    check("reset_frame_cnt", 128'(frame_cnt), 128'(0));
    rst_n = 1'b1;
    @(negedge ti_clk);

    // Two back-to-back clean frames: latency and 16-cycle spacing.
    start = cyc;
    push_std_frame(16'h1000);
    push_std_frame(16'h2000);
    drain(1'b0);
    if (got_cyc.size() >= 2) begin
      check("latency_first", 128'(got_cyc[0] - start), 128'(17));
      check("latency_second", 128'(got_cyc[1] - start), 128'(33));
    end else begin
      check("latency_frames_seen", 128'(got_cyc.size()), 128'(2));
    end
    if (got_frames.size() >= 1) check("first_frame_ch3", 128'(got_frames[0][63:48]), 128'(16'h1003));
    check_all("b2b");

    // Frame with trailer then a normal frame.
    push_std_frame(16'h3000);
    push_pair(8, 16'hBEEF);
    push_std_frame(16'h4000);
    drain(1'b0);
    check_all("trailer");

    // Malformed header ahead of a valid frame, then clear.
    push_word(16'h8003);
    push_std_frame(16'h5000);
    drain(1'b0);
    check("hdr_err_set", 128'(hdr_err), 128'(1));
    check_all("bad_hdr");
    pulse_err_clr();
    check("hdr_err_cleared", 128'(hdr_err), 128'(0));

    // Channel 2 before channel 1.
    push_pair(0, 16'h6000); push_pair(2, 16'h6002); push_pair(1, 16'h6001);
    for (int i = 3; i < 8; i++) push_pair(i, 16'h6000 + 16'(i));
    drain(1'b0);
    check("seq_err_set", 128'(seq_err), 128'(1));
    check_all("out_of_order");
    pulse_err_clr();

    // Stall with hold, then with toggling empty.
    push_std_frame(16'h7000);
    repeat (3) @(negedge ti_clk);
    hold = 1'b1;
    repeat (5) begin
      @(negedge ti_clk);
      check("hold_no_read", 128'(fifo_rd_en), 128'(0));
    end
    hold = 1'b0;
    repeat (6) @(negedge ti_clk) force_empty = ~force_empty;
    force_empty = 1'b0;
    drain(1'b0);
    check_all("stall");

    // Randomized frames with random stalls.
    for (int s = 0; s < 24; s++) begin
      ty = $urandom % 5;
      for (int i = 0; i < 8; i++) ord[i] = i;
      if (ty == 3) begin
        a = $urandom % 8; b = $urandom % 8;
        t = ord[a]; ord[a] = ord[b]; ord[b] = t;
      end
      badpos = $urandom % 8;
      dropch = $urandom % 7;
      if ($urandom % 2) bad = {12'($urandom_range(1, 4095)), 4'($urandom)};
      else bad = {12'h000, 4'($urandom_range(9, 15))};
      for (int k = 0; k < 8; k++) begin
        if (ty == 2 && k == badpos) push_word(bad);
        if (!(ty == 4 && ord[k] == dropch)) push_pair(ord[k], 16'($urandom));
      end
      if (ty == 1) push_pair(8, 16'($urandom));
      drain(1'b1);
      check_all($sformatf("rand%0d_t%0d", s, ty));
      if ($urandom % 3 == 0) begin
        pulse_err_clr();
        check("rand_clr_hdr", 128'(hdr_err), 128'(0));
        check("rand_clr_seq", 128'(seq_err), 128'(0));
      end
    end

    // Reset mid-frame after errors have been raised.
    push_word(16'hFFFF);
    push_pair(0, 16'h8000); push_pair(1, 16'h8001); push_pair(3, 16'h8003);
    drain(1'b0);
    @(negedge ti_clk) rst_n = 1'b0;
    model_reset();
    exp_frames.delete();
    push_word(16'h0000);
    #1;
    check("midrst_rd_en", 128'(fifo_rd_en), 128'(0));
    check("midrst_ch_data", ch_data, 128'(0));
    check("midrst_frame_valid", 128'(frame_valid), 128'(0));
    check("midrst_hdr_err", 128'(hdr_err), 128'(0));
    check("midrst_seq_err", 128'(seq_err), 128'(0));
    check("midrst_frame_cnt", 128'(frame_cnt), 128'(0));
    @(negedge ti_clk) rst_n = 1'b1;
    push_word(16'h9000);
    for (int i = 1; i < 8; i++) push_pair(i, 16'h9000 + 16'(i));
    drain(1'b0);
    check_all("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
